// File: rtl/iter_shift_unit.sv
// Bit-serial shift engine: accepts one operand under valid/ready, shifts it one
// position per clock (SLL/SRL/SRA/ROL), and returns the result under valid/ready.
module iter_shift_unit #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } op_t;

  state_t           r_state;
  state_t           w_next_state;
  op_t              r_op;
  logic [WIDTH-1:0] r_data;
  logic [AMT_W-1:0] r_cnt;
  logic             r_carry;

  logic [WIDTH-1:0] w_step_data;
  logic             w_step_carry;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_next_state = (in_amt == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_cnt == AMT_W'(1)) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // One single-bit step of the captured operation.
  always_comb begin
    w_step_data  = r_data;
    w_step_carry = r_carry;
    unique case (r_op)
      OP_SLL: begin
        w_step_carry = r_data[WIDTH-1];
        w_step_data  = {r_data[WIDTH-2:0], 1'b0};
      end
      OP_SRL: begin
        w_step_carry = r_data[0];
        w_step_data  = {1'b0, r_data[WIDTH-1:1]};
      end
      OP_SRA: begin
        w_step_carry = r_data[0];
        w_step_data  = {r_data[WIDTH-1], r_data[WIDTH-1:1]};
      end
      OP_ROL: begin
        w_step_carry = r_data[WIDTH-1];
        w_step_data  = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
      end
      default: begin
        w_step_data  = r_data;
        w_step_carry = r_carry;
      end
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so all registers update
  // together from values sampled before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_op    <= OP_SLL;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_data  <= in_data;
            r_cnt   <= in_amt;
            r_op    <= op_t'(in_op);
            r_carry <= 1'b0;
          end
        end
        S_SHIFT: begin
          r_data  <= w_step_data;
          r_carry <= w_step_carry;
          r_cnt   <= r_cnt - AMT_W'(1);
        end
        default: begin
          // DONE holds the result stable until the consumer takes it.
          r_data  <= r_data;
          r_carry <= r_carry;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_SHIFT);
  assign out_data  = r_data;
  assign out_carry = r_carry;
  assign out_zero  = (r_data == '0);

endmodule

// File: tb/tb_iter_shift_unit.sv
// Directed bench for iter_shift_unit: hand-computed vectors covering each op,
// amount boundaries, backpressure, asynchronous reset and ignored inputs.
module tb_iter_shift_unit;

  localparam int WIDTH = 4;
  localparam int AMT_W = 3;

  localparam logic [1:0] SLL = 2'b00;
  localparam logic [1:0] SRL = 2'b01;
  localparam logic [1:0] SRA = 2'b10;
  localparam logic [1:0] ROL = 2'b11;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             out_zero;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;

  iter_shift_unit #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_zero  (out_zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"},  32'(out_data),  32'd0);
    check({tag, "_out_carry"}, 32'(out_carry), 32'd0);
    check({tag, "_out_zero"},  32'(out_zero),  32'd1);
    check({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  // Issues one command (caller is 1 time unit after a rising edge), waits for
  // the result, checks it, holds backpressure for 'hold' cycles, then consumes it.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [WIDTH-1:0] data,
                        input logic [AMT_W-1:0] amt, input logic [WIDTH-1:0] exp_data,
                        input logic exp_carry, input int hold, input bit toggle);
    int edges;
    int busy_cycles;
    logic [WIDTH-1:0] held_data;
    logic             held_carry;
    logic             held_zero;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = data;
    in_amt   = amt;
    in_op    = op;
    edges       = 0;
    busy_cycles = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
      if (busy) busy_cycles++;
      if (toggle && busy) begin
        in_valid = 1'($urandom);
        in_data  = WIDTH'($urandom);
        in_amt   = AMT_W'($urandom);
        in_op    = 2'($urandom);
      end else begin
        in_valid = 1'b0;
      end
    end while (!out_valid && edges < 40);
    in_valid = 1'b0;
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_latency"},   32'(edges),     32'(amt) + 32'd1);
    check({tag, "_busy_cyc"},  32'(busy_cycles), 32'(amt));
    check({tag, "_data"},      32'(out_data),  32'(exp_data));
    check({tag, "_carry"},     32'(out_carry), 32'(exp_carry));
    check({tag, "_zero"},      32'(out_zero),  32'(exp_data == '0));
    held_data  = out_data;
    held_carry = out_carry;
    held_zero  = out_zero;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_bp_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_bp_ready"}, 32'(in_ready),  32'd0);
      check({tag, "_bp_data"},  32'(out_data),  32'(held_data));
      check({tag, "_bp_carry"}, 32'(out_carry), 32'(held_carry));
      check({tag, "_bp_zero"},  32'(out_zero),  32'(held_zero));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_idle_ready"}, 32'(in_ready),  32'd1);
    check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_op     = SLL;
    out_ready = 1'b0;
    #3;
    check_reset_outputs("por");
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;

    //     tag         op   data     amt   exp_data exp_c hold toggle
    run_op("sra_1",    SRA, 4'b1100, 3'd1, 4'b1110, 1'b0, 0, 1'b0);
    run_op("sll_1",    SLL, 4'b1100, 3'd1, 4'b1000, 1'b1, 0, 1'b0);
    run_op("srl_4",    SRL, 4'b1010, 3'd4, 4'b0000, 1'b1, 0, 1'b0);
    run_op("rol_5",    ROL, 4'b1110, 3'd5, 4'b1101, 1'b1, 0, 1'b0);
    run_op("amt0",     SLL, 4'b0010, 3'd0, 4'b0010, 1'b0, 0, 1'b0);
    run_op("sra_6",    SRA, 4'b1001, 3'd6, 4'b1111, 1'b1, 0, 1'b0);
    run_op("srl_2",    SRL, 4'b0110, 3'd2, 4'b0001, 1'b1, 0, 1'b0);
    run_op("sll_7",    SLL, 4'b1111, 3'd7, 4'b0000, 1'b0, 0, 1'b0);
    run_op("rol_7_bp", ROL, 4'b1000, 3'd7, 4'b0100, 1'b0, 5, 1'b0);
    run_op("sra_3_tg", SRA, 4'b0111, 3'd3, 4'b0000, 1'b1, 0, 1'b1);

    // Exactly one result per accepted command: no stray output afterwards.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("no_extra_valid", 32'(out_valid), 32'd0);
      check("no_extra_busy",  32'(busy),      32'd0);
    end

    // Reset in the middle of SRL by 7, after three shift edges.
    in_valid = 1'b1;
    in_data  = 4'b1011;
    in_amt   = 3'd7;
    in_op    = SRL;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
    check("mid_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_op("post_rst", SLL, 4'b0001, 3'd2, 4'b0100, 1'b0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
